// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and types for the adder comparison suite
// Purpose: operand width and word type used by every adder in the suite.
// Ports: none (package).
package adder_pkg;

    localparam int ADDER_W = 64;

    typedef logic [ADDER_W-1:0] word_t;

endpackage

// File: rtl/rca_64_if.sv
// rtl/rca_64_if.sv - operand/result bundle for the 64-bit ripple-carry adder
// Purpose: groups adder operands and registered results.
// Signals:
//   a, b  operands (driven by master)
//   cin   carry into bit 0 (driven by master)
//   sum   registered sum (driven by slave)
//   cout  registered carry out (driven by slave)
interface rca_64_if;
    import adder_pkg::*;

    word_t a;
    word_t b;
    logic  cin;
    word_t sum;
    logic  cout;

    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output cout
    );

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit combinational full adder cell
// Purpose: single stage of the ripple-carry chain.
// Ports:
//   s   out  sum bit a^b^ci
//   co  out  carry out a&b | ci&(a^b)
//   a   in   operand bit
//   b   in   operand bit
//   ci  in   carry in
module full_adder (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    logic p;

    // Propagate term shared by the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rca_64.sv
// rtl/rca_64.sv - 64-bit unsigned ripple-carry adder with registered outputs
// Purpose: {cout,sum} <= a + b + cin through a strict chain of full_adder
//          cells, captured on the rising clock edge (1-cycle latency).
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset; clears sum and cout
//   bus  slave modport of rca_64_if (a, b, cin in; sum, cout out)
module rca_64
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_W
) (
    input logic    clk,
    input logic    rst,
    rca_64_if.slave bus
);

    // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    assign c[0] = bus.cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .s  (s[i]),
                .co (c[i+1]),
                .a  (bus.a[i]),
                .b  (bus.b[i]),
                .ci (c[i])
            );
        end
    endgenerate

    always_comb begin
        sum_d  = s;
        cout_d = c[WIDTH];
    end

    // Reset wins over the adder result so a pending sum is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_rca_64.sv
// tb/tb_rca_64.sv - scoreboard bench for rca_64
module tb_rca_64;
    import adder_pkg::*;

    typedef struct {
        logic [64:0] exp;
        int          due;
        string       name;
    } item_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   passed;
    bit   drive_done;

    item_t sb_q[$];

    rca_64_if bus_if ();

    rca_64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue one vector; the expected 65-bit result is pushed for the edge
    // that will capture it.
    task automatic drive(input logic r, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input string nm);
        item_t it;
        @(posedge clk);
        #1;
        rst         = r;
        bus_if.a    = a;
        bus_if.b    = b;
        bus_if.cin  = ci;
        it.exp  = r ? 65'd0 : ({1'b0, a} + {1'b0, b} + {64'd0, ci});
        it.due  = cyc + 1;
        it.name = nm;
        sb_q.push_back(it);
    endtask

    // Monitor: on each falling edge, retire every expectation whose
    // capture edge has already happened.
    initial begin
        item_t it;
        logic [64:0] got;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                it  = sb_q.pop_front();
                got = {bus_if.cout, bus_if.sum};
                checks++;
                if (got === it.exp) passed++;
                else $display("FAIL %s: got cout=%0b sum=%h, expected cout=%0b sum=%h",
                              it.name, got[64], got[63:0], it.exp[64], it.exp[63:0]);
            end
        end
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        int          sel;
        int          waited;
        checks     = 0;
        passed     = 0;
        drive_done = 0;
        rst        = 1'b1;
        bus_if.a   = '0;
        bus_if.b   = '0;
        bus_if.cin = 1'b0;

        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, "reset_0");
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, "reset_1");
        drive(1'b0, 64'd998, 64'd128, 1'b0, "add_998_128");
        drive(1'b0, 64'd9998, 64'd9028, 1'b0, "add_9998_9028");
        drive(1'b0, 64'd9989998, 64'd769028, 1'b0, "add_9989998_769028");
        drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, "ripple_wrap");
        drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "all_ones_cin");
        drive(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "msb_carry");
        drive(1'b1, 64'd5, 64'd7, 1'b0, "reset_mid_op");
        drive(1'b0, 64'd5, 64'd7, 1'b0, "after_reset_12");

        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 7);
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rc  = 1'($urandom_range(0, 1));
            // Bias some vectors toward long carry chains.
            if (sel == 0) rb = ~ra;
            if (sel == 1) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            drive(1'b0, ra, rb, rc, "random");
        end
        drive_done = 1;

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
